sim_dsp_simd_mac: RTL and testbench

//  Parametrised N-channel SIMD multiply-accumulate for simulation/inference tests of QLF K6N10F DSP packing.

---
 rtl/sim_dsp_simd_mac_if.sv | 32 +++
 rtl/sim_dsp_simd_mac.sv | 154 +++++++++++++++
 tb/tb_sim_dsp_simd_mac.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sim_dsp_simd_mac_if.sv
// Bundle of the sample-in / result-out signals of the SIMD multiply-accumulate.
// The master drives samples and control; the slave (the MAC) returns results.
interface sim_dsp_simd_mac_if #(
  parameter int NUM_CH = 2,
  parameter int A_W    = 10,
  parameter int B_W    = 9,
  parameter int Z_W    = 19
);
  logic                  in_valid_i;
  logic [NUM_CH*A_W-1:0] a_i;
  logic [NUM_CH*B_W-1:0] b_i;
  logic                  unsigned_a_i;
  logic                  unsigned_b_i;
  logic                  acc_en_i;
  logic [NUM_CH-1:0]     load_acc_i;
  logic                  subtract_i;
  logic                  out_valid_o;
  logic [NUM_CH*Z_W-1:0] z_o;
  logic [NUM_CH-1:0]     ovf_o;

  modport master (
    output in_valid_i, a_i, b_i, unsigned_a_i, unsigned_b_i,
           acc_en_i, load_acc_i, subtract_i,
    input  out_valid_o, z_o, ovf_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, unsigned_a_i, unsigned_b_i,
           acc_en_i, load_acc_i, subtract_i,
    output out_valid_o, z_o, ovf_o
  );
endinterface

// File: rtl/sim_dsp_simd_mac.sv
// N-lane SIMD multiply-accumulate with a fixed 3-stage pipeline:
// S1 operand capture, S2 signed/unsigned product, S3 accumulate, shift,
// saturate or truncate, and output register. One sample per cycle, no stall.
module sim_dsp_simd_mac #(
  parameter int NUM_CH      = 2,
  parameter int A_W         = 10,
  parameter int B_W         = 9,
  parameter int ACC_W       = 32,
  parameter int Z_W         = 19,
  parameter int SHIFT_RIGHT = 0,
  parameter int SATURATE    = 0
) (
  input logic               clk,
  input logic               rst,
  sim_dsp_simd_mac_if.slave bus
);
  // The true product of (A_W+1)x(B_W+1) extended operands always fits in
  // A_W+B_W+1 signed bits, so the multiply is carried out modulo 2^P_W.
  localparam int P_W = A_W + B_W + 1;

  // Stage 1 registers
  logic                  s1_valid;
  logic [NUM_CH*A_W-1:0] s1_a;
  logic [NUM_CH*B_W-1:0] s1_b;
  logic                  s1_ua;
  logic                  s1_ub;
  logic                  s1_acc_en;
  logic                  s1_sub;
  logic [NUM_CH-1:0]     s1_load;

  // Stage 2 registers
  logic                  s2_valid;
  logic                  s2_acc_en;
  logic                  s2_sub;
  logic [NUM_CH-1:0]     s2_load;
  logic signed [P_W-1:0] s2_prod [NUM_CH];

  // Stage 3 registers
  logic signed [ACC_W-1:0] acc [NUM_CH];
  logic                    out_valid_q;
  logic [NUM_CH*Z_W-1:0]   z_q;
  logic [NUM_CH-1:0]       ovf_q;

  // Combinational helpers
  logic signed [P_W-1:0]   ext_a    [NUM_CH];
  logic signed [P_W-1:0]   ext_b    [NUM_CH];
  logic signed [P_W-1:0]   prod     [NUM_CH];
  logic signed [ACC_W-1:0] p_ext    [NUM_CH];
  logic signed [ACC_W-1:0] acc_nxt  [NUM_CH];
  logic signed [ACC_W-1:0] res      [NUM_CH];
  logic [NUM_CH-1:0]       restart;
  logic [NUM_CH-1:0]       fits;
  logic [NUM_CH*Z_W-1:0]   z_nxt;
  logic [NUM_CH-1:0]       ovf_nxt;

  assign bus.out_valid_o = out_valid_q;
  assign bus.z_o         = z_q;
  assign bus.ovf_o       = ovf_q;

  // S1: capture operands and control only for valid samples; valid always follows the input
  always_ff @(posedge clk) begin
    // NOTE: registers are written with non-blocking assignments so every stage samples pre-edge values.
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_ua     <= 1'b0;
      s1_ub     <= 1'b0;
      s1_acc_en <= 1'b0;
      s1_sub    <= 1'b0;
      s1_load   <= '0;
    end else begin
      s1_valid <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        s1_a      <= bus.a_i;
        s1_b      <= bus.b_i;
        s1_ua     <= bus.unsigned_a_i;
        s1_ub     <= bus.unsigned_b_i;
        s1_acc_en <= bus.acc_en_i;
        s1_sub    <= bus.subtract_i;
        s1_load   <= bus.load_acc_i;
      end
    end
  end

  // S2 datapath: sign- or zero-extend each lane's operands and multiply
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ext_a[k] = $signed({{(P_W-A_W){~s1_ua & s1_a[k*A_W+A_W-1]}}, s1_a[k*A_W +: A_W]});
      ext_b[k] = $signed({{(P_W-B_W){~s1_ub & s1_b[k*B_W+B_W-1]}}, s1_b[k*B_W +: B_W]});
      prod[k]  = ext_a[k] * ext_b[k];
    end
  end

  // S2: register products and the control that S3 needs
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_acc_en <= 1'b0;
      s2_sub    <= 1'b0;
      s2_load   <= '0;
      for (int k = 0; k < NUM_CH; k++) s2_prod[k] <= '0;
    end else begin
      s2_valid  <= s1_valid;
      s2_acc_en <= s1_acc_en;
      s2_sub    <= s1_sub;
      s2_load   <= s1_load;
      for (int k = 0; k < NUM_CH; k++) s2_prod[k] <= prod[k];
    end
  end

  // S3 datapath: next accumulator, shifted result, clamp or truncate, sticky overflow
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    z_nxt   = '0;
    ovf_nxt = '0;
    restart = '0;
    fits    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      p_ext[k]   = s2_sub ? -ACC_W'(s2_prod[k]) : ACC_W'(s2_prod[k]);
      restart[k] = ~s2_acc_en | s2_load[k];
      acc_nxt[k] = restart[k] ? p_ext[k] : acc[k] + p_ext[k];
      res[k]     = acc_nxt[k] >>> SHIFT_RIGHT;
      // Fits in Z_W signed bits when every bit above the result sign bit matches it.
      fits[k]    = (&res[k][ACC_W-1:Z_W-1]) | ~(|res[k][ACC_W-1:Z_W-1]);
      if (SATURATE != 0 && !fits[k]) begin
        z_nxt[k*Z_W +: Z_W] = res[k][ACC_W-1] ? {1'b1, {(Z_W-1){1'b0}}}
                                              : {1'b0, {(Z_W-1){1'b1}}};
      end else begin
        z_nxt[k*Z_W +: Z_W] = res[k][Z_W-1:0];
      end
      // A restart clears the flag, but an overflow on that same sample still sets it.
      ovf_nxt[k] = (ovf_q[k] & ~restart[k]) | ~fits[k];
    end
  end

  // S3: update accumulators and outputs only for valid samples; bubbles hold everything
  always_ff @(posedge clk) begin
    // NOTE: the accumulators are plain registers, not a memory, so they are reset with the rest.
    if (rst) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
      ovf_q       <= '0;
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else begin
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        z_q   <= z_nxt;
        ovf_q <= ovf_nxt;
        for (int k = 0; k < NUM_CH; k++) acc[k] <= acc_nxt[k];
      end
    end
  end
endmodule

// File: tb/tb_sim_dsp_simd_mac.sv
// Self-checking bench: three MAC instances (plain, saturating, shift-by-4) see
// identical stimulus; a per-sample arithmetic model predicts each result.
module tb_sim_dsp_simd_mac;
  localparam int NUM_CH = 2;
  localparam int A_W    = 10;
  localparam int B_W    = 9;
  localparam int ACC_W  = 32;
  localparam int Z_W    = 19;
  localparam int NCFG   = 3;
  localparam int SHIFT_TAB [NCFG] = '{0, 0, 4};
  localparam int SAT_TAB   [NCFG] = '{0, 1, 0};
  localparam longint ZMAX = (longint'(1) << (Z_W-1)) - 1;
  localparam longint ZMIN = -(ZMAX + 1);

  typedef struct packed {
    int                                 due;
    logic [NCFG-1:0][NUM_CH*Z_W-1:0]    z;
    logic [NCFG-1:0][NUM_CH-1:0]        ovf;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic [NUM_CH*A_W-1:0] a_bus;
  logic [NUM_CH*B_W-1:0] b_bus;
  logic                  ua, ub, acc_en, sub;
  logic [NUM_CH-1:0]     load;

  logic                  out_valid [NCFG];
  logic [NUM_CH*Z_W-1:0] z_obs     [NCFG];
  logic [NUM_CH-1:0]     ovf_obs   [NCFG];

  exp_t   q[$];
  exp_t   cur;
  int     m_acc [NCFG][NUM_CH];
  bit     m_ovf [NCFG][NUM_CH];
  int     ncyc;
  int     n_checks;
  int     n_errors;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    sim_dsp_simd_mac_if #(.NUM_CH(NUM_CH), .A_W(A_W), .B_W(B_W), .Z_W(Z_W)) bus ();
    assign bus.in_valid_i   = in_valid;
    assign bus.a_i          = a_bus;
    assign bus.b_i          = b_bus;
    assign bus.unsigned_a_i = ua;
    assign bus.unsigned_b_i = ub;
    assign bus.acc_en_i     = acc_en;
    assign bus.load_acc_i   = load;
    assign bus.subtract_i   = sub;
    assign out_valid[g]     = bus.out_valid_o;
    assign z_obs[g]         = bus.z_o;
    assign ovf_obs[g]       = bus.ovf_o;
    sim_dsp_simd_mac #(
      .NUM_CH(NUM_CH), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .Z_W(Z_W),
      .SHIFT_RIGHT(SHIFT_TAB[g]), .SATURATE(SAT_TAB[g])
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, ncyc, obs, exp);
    end
  endtask

  function automatic logic [63:0] zexp(input int v);
    logic [Z_W-1:0] t;
    t = Z_W'(v);
    return {{(64-Z_W){1'b0}}, t};
  endfunction

  function automatic logic [63:0] zobs(input int c, input int k);
    logic [Z_W-1:0] t;
    t = z_obs[c][k*Z_W +: Z_W];
    return {{(64-Z_W){1'b0}}, t};
  endfunction

  // Advance to the next falling edge and compare every instance against the model.
  task automatic tick();
    bit expv;
    @(negedge clk);
    ncyc++;
    expv = 1'b0;
    if (q.size() > 0 && q[0].due == ncyc) begin
      cur  = q.pop_front();
      expv = 1'b1;
    end
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("valid_c%0d", c), 64'(out_valid[c]), 64'(expv));
      check($sformatf("z_c%0d", c), 64'(z_obs[c]), 64'(cur.z[c]));
      check($sformatf("ovf_c%0d", c), 64'(ovf_obs[c]), 64'(cur.ovf[c]));
    end
  endtask

  // Arithmetic model of one accepted sample; its result is due three cycles later.
  task automatic model_accept();
    exp_t e;
    e     = '0;
    e.due = ncyc + 3;
    for (int c = 0; c < NCFG; c++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        longint av, bv, p, zv;
        int     r;
        bit     fits, restart;
        av = ua ? longint'({1'b0, a_bus[k*A_W +: A_W]}) : longint'($signed(a_bus[k*A_W +: A_W]));
        bv = ub ? longint'({1'b0, b_bus[k*B_W +: B_W]}) : longint'($signed(b_bus[k*B_W +: B_W]));
        p  = av * bv;
        if (sub) p = -p;
        restart = !acc_en || load[k];
        m_acc[c][k] = restart ? int'(p) : int'(longint'(m_acc[c][k]) + p);
        r    = m_acc[c][k] >>> SHIFT_TAB[c];
        fits = (r <= ZMAX) && (r >= ZMIN);
        if (SAT_TAB[c] != 0 && !fits) zv = (r > 0) ? ZMAX : ZMIN;
        else                          zv = longint'(r);
        e.z[c][k*Z_W +: Z_W] = Z_W'(zv);
        m_ovf[c][k] = (restart ? 1'b0 : m_ovf[c][k]) | !fits;
        e.ovf[c][k] = m_ovf[c][k];
      end
    end
    q.push_back(e);
  endtask

  task automatic model_reset();
    q.delete();
    cur = '0;
    for (int c = 0; c < NCFG; c++)
      for (int k = 0; k < NUM_CH; k++) begin
        m_acc[c][k] = 0;
        m_ovf[c][k] = 1'b0;
      end
  endtask

  task automatic send(input bit v, input logic [NUM_CH*A_W-1:0] a, input logic [NUM_CH*B_W-1:0] b,
                      input bit fua, input bit fub, input bit fen,
                      input logic [NUM_CH-1:0] fld, input bit fsub);
    tick();
    rst      = 1'b0;
    in_valid = v;
    a_bus    = a;
    b_bus    = b;
    ua       = fua;
    ub       = fub;
    acc_en   = fen;
    load     = fld;
    sub      = fsub;
    if (v) model_accept();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
    end
  endtask

  // Reset with a valid sample on the inputs: the sample must be ignored.
  task automatic do_reset();
    tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    a_bus    = (NUM_CH*A_W)'($urandom);
    b_bus    = (NUM_CH*B_W)'($urandom);
    model_reset();
  endtask

  function automatic logic [NUM_CH*A_W-1:0] pa(input int x0, input int x1);
    return {A_W'(x1), A_W'(x0)};
  endfunction

  function automatic logic [NUM_CH*B_W-1:0] pb(input int x0, input int x1);
    return {B_W'(x1), B_W'(x0)};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    ncyc     = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a_bus    = '0;
    b_bus    = '0;
    ua       = 1'b0;
    ub       = 1'b0;
    acc_en   = 1'b0;
    load     = '0;
    sub      = 1'b0;
    model_reset();
    idle(2);

    // T1: unsigned full-scale plain multiply on both lanes
    send(1, pa(1023, 1023), pb(511, 511), 1, 1, 0, 2'b00, 0);
    idle(4);
    check("t1_z_lane0", zobs(0, 0), zexp(522753));
    check("t1_z_lane1", zobs(0, 1), zexp(522753));

    // T2: signed accumulate with a bubble between samples 2 and 3
    send(1, pa(-3, -3), pb(5, 5), 0, 0, 1, 2'b11, 0);
    send(1, pa(-3, -3), pb(5, 5), 0, 0, 1, 2'b00, 0);
    idle(1);
    send(1, pa(-3, -3), pb(5, 5), 0, 0, 1, 2'b00, 0);
    send(1, pa(-3, -3), pb(5, 5), 0, 0, 1, 2'b00, 0);
    idle(4);
    check("t2_z", zobs(0, 0), zexp(-60));

    // T3: saturation and sticky overflow, then a load clears it
    send(1, pa(511, 511), pb(255, 255), 0, 0, 1, 2'b11, 0);
    repeat (3) send(1, pa(511, 511), pb(255, 255), 0, 0, 1, 2'b00, 0);
    idle(4);
    check("t3_z_clamp", zobs(1, 0), zexp(262143));
    check("t3_ovf_set", 64'(ovf_obs[1][0]), 64'(1));
    send(1, pa(1, 1), pb(1, 1), 0, 0, 1, 2'b11, 0);
    idle(4);
    check("t3_ovf_clr", 64'(ovf_obs[1][0]), 64'(0));

    // T4: subtract with independent per-lane load
    send(1, pa(2, 0), pb(3, 0), 0, 0, 1, 2'b01, 1);
    send(1, pa(2, 1), pb(3, 1), 0, 0, 1, 2'b10, 1);
    idle(4);
    check("t4_lane0", zobs(0, 0), zexp(-12));
    check("t4_lane1", zobs(0, 1), zexp(-1));

    // T5: arithmetic right shift by 4
    send(1, pa(160, 160), pb(1, 1), 1, 1, 0, 2'b00, 0);
    idle(4);
    check("t5_pos", zobs(2, 0), zexp(10));
    send(1, pa(-16, -16), pb(1, 1), 0, 0, 0, 2'b00, 0);
    idle(4);
    check("t5_neg", zobs(2, 0), zexp(-1));

    // T6: reset discards in-flight samples; accumulation restarts from zero
    send(1, pa(7, 7), pb(7, 7), 0, 0, 1, 2'b11, 0);
    send(1, pa(7, 7), pb(7, 7), 0, 0, 1, 2'b00, 0);
    do_reset();
    idle(5);
    check("t6_z_zero", zobs(0, 0), zexp(0));
    send(1, pa(2, 2), pb(3, 3), 0, 0, 1, 2'b00, 0);
    idle(4);
    check("t6_acc_from_0", zobs(0, 0), zexp(6));

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else begin
        send(r < 75,
             (NUM_CH*A_W)'($urandom), (NUM_CH*B_W)'($urandom),
             1'($urandom), 1'($urandom),
             $urandom_range(0, 7) != 0,
             ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0,
             1'($urandom));
      end
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
